multi_debouncer: RTL and testbench

Parametrised N-channel push-button debouncer; next generation of the single-button toggle debouncer. Each channel synchronises a raw button into CLK, qualifies it with a stable-sample count taken on DIV_CLK enable ticks, and drives a per-channel output in level (momentary) or toggle mode, plus one-cycle press/release pulses. Sits between the board buttons and the timer control FSM; the shared prescaler supplies DIV_CLK.

---
 rtl/multi_debouncer_pkg.sv | 25 ++
 rtl/debounce_channel.sv | 132 +++++++++++++
 rtl/multi_debouncer.sv | 60 ++++++
 tb/tb_multi_debouncer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_debouncer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | multi_debouncer_pkg                                               |
// | Shared debouncer state encoding and channel mode constants.       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package multi_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'b00,
    COUNT_HIGH = 2'b01,
    IDLE_HIGH  = 2'b10,
    COUNT_LOW  = 2'b11
  } deb_state_e;

  localparam logic MODE_LEVEL  = 1'b0;
  localparam logic MODE_TOGGLE = 1'b1;

  // The state is fully implied by the stable level and whether a count is running.
  function automatic deb_state_e deb_state(input logic level, input logic counting);
    return deb_state_e'({level, counting});
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// +------------------------------------------------------------------+
// | debounce_channel                                                  |
// | One button: 2-flop synchroniser, stable-tick qualifier, toggle    |
// | register and press/release pulses. LONG_PRESS_EN adds long-press. |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module debounce_channel
  import multi_debouncer_pkg::*;
#(
  parameter int   STABLE_TICKS = 25,
  parameter int   CNT_WIDTH    = 5,
  parameter logic INVERT       = 1'b0
`ifdef LONG_PRESS_EN
  ,
  parameter int   LONG_TICKS   = 80
`endif
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_div_clk,
  input  logic i_btn,
  input  logic i_mode,
  output logic o_out,
  output logic o_press,
  output logic o_release
`ifdef LONG_PRESS_EN
  ,
  output logic o_long
`endif
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(STABLE_TICKS - 1);

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 level_q, level_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 toggle_q, toggle_d;
  logic                 press_q, press_d;
  logic                 rel_q, rel_d;
  logic                 sample;
  deb_state_e           state;

  always_comb begin
    sync1_d = i_btn;
    sync2_d = sync1_q;
    sample  = sync2_q ^ INVERT;
    state   = deb_state(level_q, cnt_q != '0);
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (i_div_clk) begin
      unique case (state)
        IDLE_LOW, IDLE_HIGH: begin
          if (sample != level_q) cnt_d = CNT_WIDTH'(1);
        end
        COUNT_HIGH, COUNT_LOW: begin
          if (sample == level_q) begin
            cnt_d = '0;
          end else if (cnt_q == LAST_CNT) begin
            level_d = sample;
            cnt_d   = '0;
            press_d = sample;
            rel_d   = ~sample;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end
    // Tracking the new level in level mode makes a later switch to toggle start from L.
    toggle_d = (i_mode == MODE_TOGGLE) ? (toggle_q ^ press_d) : level_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      level_q  <= 1'b0;
      cnt_q    <= '0;
      toggle_q <= 1'b0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      toggle_q <= toggle_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
    end
  end

  assign o_out     = (i_mode == MODE_TOGGLE) ? toggle_q : level_q;
  assign o_press   = press_q;
  assign o_release = rel_q;

`ifdef LONG_PRESS_EN
  localparam int LONG_W = $clog2(LONG_TICKS + 1);

  logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
  logic              long_q, long_d;

  always_comb begin
    long_cnt_d = long_cnt_q;
    if (!level_q) begin
      long_cnt_d = '0;
    end else if (i_div_clk && (long_cnt_q != LONG_W'(LONG_TICKS))) begin
      long_cnt_d = long_cnt_q + 1'b1;
    end
    long_d = (long_cnt_d == LONG_W'(LONG_TICKS - 1)) &&
             (long_cnt_q != LONG_W'(LONG_TICKS - 1));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      long_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      long_cnt_q <= long_cnt_d;
      long_q     <= long_d;
    end
  end

  assign o_long = long_q;
`endif

endmodule
`default_nettype wire

// File: rtl/multi_debouncer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | multi_debouncer                                                   |
// | N independent button debouncers sharing one DIV_CLK sample tick.  |
// | Optional LONG_PRESS_EN adds LONG_TICKS and the LONG output.       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module multi_debouncer
  import multi_debouncer_pkg::*;
#(
  parameter int                  CHANNELS     = 5,
  parameter int                  STABLE_TICKS = 25,
  parameter int                  CNT_WIDTH    = 5,
  parameter logic [CHANNELS-1:0] INVERT_MASK  = {CHANNELS{1'b0}}
`ifdef LONG_PRESS_EN
  ,
  parameter int                  LONG_TICKS   = 80
`endif
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                DIV_CLK,
  input  logic [CHANNELS-1:0] IN,
  input  logic [CHANNELS-1:0] MODE,
  output logic [CHANNELS-1:0] OUT,
  output logic [CHANNELS-1:0] PRESS,
  output logic [CHANNELS-1:0] RELEASE
`ifdef LONG_PRESS_EN
  ,
  output logic [CHANNELS-1:0] LONG
`endif
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .CNT_WIDTH    (CNT_WIDTH),
      .INVERT       (INVERT_MASK[g])
`ifdef LONG_PRESS_EN
      ,
      .LONG_TICKS   (LONG_TICKS)
`endif
    ) u_chan (
      .i_clk     (CLK),
      .i_rst_n   (RESET_N),
      .i_div_clk (DIV_CLK),
      .i_btn     (IN[g]),
      .i_mode    (MODE[g]),
      .o_out     (OUT[g]),
      .o_press   (PRESS[g]),
      .o_release (RELEASE[g])
`ifdef LONG_PRESS_EN
      ,
      .o_long    (LONG[g])
`endif
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_debouncer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_multi_debouncer                                                |
// | Directed and random stimulus against a tick-run reference model.  |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_multi_debouncer;

  localparam int         CH  = 5;
  localparam int         ST  = 4;
  localparam logic [4:0] INV = 5'b01000;

  logic       clk = 1'b0;
  logic       RESET_N;
  logic       DIV_CLK;
  logic [4:0] IN;
  logic [4:0] MODE;
  logic [4:0] OUT;
  logic [4:0] PRESS;
  logic [4:0] RELEASE;

  always #5 clk = ~clk;

  multi_debouncer #(
    .CHANNELS     (CH),
    .STABLE_TICKS (ST),
    .CNT_WIDTH    (3),
    .INVERT_MASK  (INV)
  ) dut (
    .CLK     (clk),
    .RESET_N (RESET_N),
    .DIV_CLK (DIV_CLK),
    .IN      (IN),
    .MODE    (MODE),
    .OUT     (OUT),
    .PRESS   (PRESS),
    .RELEASE (RELEASE)
  );

  int tests = 0;
  int fails = 0;
  int phase = 0;
  bit rand_div = 0;
  int ticks_since = 0;
  bit both_seen = 0;

  // Reference: samples seen two edges late, and the length of the current
  // run of consecutive ticks on which the sample disagreed with the level.
  logic [4:0] m_s1, m_s2, m_L, m_tog, m_press, m_rel;
  int         m_run[CH];
  int         press_cnt[CH];
  int         rel_cnt[CH];
  int         press_tick[CH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_edge();
    logic s;
    if (!RESET_N) begin
      m_s1 = '0; m_s2 = '0; m_L = '0; m_tog = '0; m_press = '0; m_rel = '0;
      for (int i = 0; i < CH; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        s = m_s2[i] ^ INV[i];
        m_press[i] = 1'b0;
        m_rel[i]   = 1'b0;
        if (DIV_CLK) begin
          if (s == m_L[i]) m_run[i] = 0;
          else begin
            m_run[i]++;
            if (m_run[i] == ST) begin
              m_L[i]     = s;
              m_run[i]   = 0;
              m_press[i] = s;
              m_rel[i]   = ~s;
            end
          end
        end
        m_tog[i] = MODE[i] ? (m_tog[i] ^ m_press[i]) : m_L[i];
      end
      m_s2 = m_s1;
      m_s1 = IN;
    end
  endfunction

  task automatic step();
    logic [4:0] exp_out;
    if (rand_div) DIV_CLK = ($urandom_range(0, 2) == 0);
    else begin
      DIV_CLK = (phase == 3);
      phase   = (phase + 1) % 4;
    end
    @(posedge clk);
    model_edge();
    if (DIV_CLK && RESET_N) ticks_since++;
    #1;
    for (int i = 0; i < CH; i++) exp_out[i] = MODE[i] ? m_tog[i] : m_L[i];
    chk("out", 32'(OUT), 32'(exp_out));
    chk("press", 32'(PRESS), 32'(m_press));
    chk("release", 32'(RELEASE), 32'(m_rel));
    for (int i = 0; i < CH; i++) begin
      if (PRESS[i] === 1'b1) begin
        press_cnt[i]++;
        press_tick[i] = ticks_since;
      end
      if (RELEASE[i] === 1'b1) rel_cnt[i]++;
    end
    if (PRESS[3] === 1'b1 && PRESS[4] === 1'b1) both_seen = 1;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < CH; i++) begin
      press_cnt[i]  = 0;
      rel_cnt[i]    = 0;
      press_tick[i] = -1;
    end
  endtask

  initial begin
    logic exp_t;
    RESET_N = 1'b0; IN = 5'b11111; MODE = 5'b00000; DIV_CLK = 1'b0;
    clear_counts();

    // Reset with all buttons driven high.
    repeat (3) begin
      step();
      chk("rst_out", 32'(OUT), 32'd0);
      chk("rst_press", 32'(PRESS), 32'd0);
      chk("rst_release", 32'(RELEASE), 32'd0);
    end
    RESET_N = 1'b1; phase = 0; ticks_since = 0; clear_counts();
    repeat (20) step();
    chk("rst_first_press_tick", 32'(press_tick[0]), 32'(ST));
    chk("rst_press_once", 32'(press_cnt[0]), 32'd1);
    chk("rst_inverted_no_press", 32'(press_cnt[3]), 32'd0);
    chk("rst_out_after", 32'(OUT), 32'b10111);
    repeat (40) step();
    chk("hold_no_repeat", 32'(press_cnt[0]), 32'd1);
    IN = 5'b01000;
    repeat (24) step();
    chk("all_released", 32'(OUT), 32'd0);

    // Clean press and release on channel 0.
    clear_counts();
    IN[0] = 1'b1;
    repeat (24) step();
    chk("clean_press_cnt", 32'(press_cnt[0]), 32'd1);
    chk("clean_out_hi", 32'(OUT[0]), 32'd1);
    IN[0] = 1'b0;
    repeat (24) step();
    chk("clean_rel_cnt", 32'(rel_cnt[0]), 32'd1);
    chk("clean_out_lo", 32'(OUT[0]), 32'd0);

    // Bounce on channel 1: 3 ticks high, 1 low, then 4 high.
    clear_counts();
    IN[1] = 1'b1; repeat (12) step();
    IN[1] = 1'b0; repeat (4) step();
    IN[1] = 1'b1; repeat (14) step();
    chk("bounce_no_early_press", 32'(press_cnt[1]), 32'd0);
    repeat (6) step();
    chk("bounce_press_after_run", 32'(press_cnt[1]), 32'd1);
    IN[1] = 1'b0; repeat (24) step();

    // Toggle mode on channel 2.
    clear_counts();
    MODE[2] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_t = (k == 0);
      IN[2] = 1'b1; repeat (24) step();
      chk("toggle_after_press", 32'(OUT[2]), 32'(exp_t));
      IN[2] = 1'b0; repeat (24) step();
      chk("toggle_after_release", 32'(OUT[2]), 32'(exp_t));
    end
    chk("toggle_press_cnt", 32'(press_cnt[2]), 32'd2);
    MODE[2] = 1'b0;

    // Inverted and normal channel pressed together.
    clear_counts(); both_seen = 0;
    IN[3] = 1'b0; IN[4] = 1'b1;
    repeat (24) step();
    chk("multi_same_cycle", 32'(both_seen), 32'd1);
    chk("multi_press3", 32'(press_cnt[3]), 32'd1);
    IN = 5'b01000; repeat (24) step();

    // Reset in the middle of a count.
    clear_counts();
    IN[0] = 1'b1; repeat (8) step();
    RESET_N = 1'b0; repeat (2) step();
    chk("midrst_no_pulse", 32'(press_cnt[0]), 32'd0);
    chk("midrst_out", 32'(OUT[0]), 32'd0);
    RESET_N = 1'b1; phase = 0; ticks_since = 0;
    repeat (20) step();
    chk("midrst_restart_tick", 32'(press_tick[0]), 32'(ST));
    IN = 5'b01000; repeat (24) step();

    // Random buttons, ticks, modes and occasional resets.
    rand_div = 1;
    repeat (1000) begin
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 15) == 0) IN[i] = ~IN[i];
      if ($urandom_range(0, 99) == 0) MODE = 5'($urandom);
      RESET_N = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
